fft_sm_input_loader: RTL and testbench
======================================

Name: fft_sm_input_loader

Overview:
Sequential successor to the combinational initial-sample table. It streams one frame of N = 2**LOG2N real input samples from a sample ROM into the FFT working memory, one sample per cycle. Each sample goes to its bit-reversed address (or natural address), sign-extended and scaled to DATA_W, with zero imaginary part. It sits between the sample ROM and the FFT state machine's memory write port, and is kicked by a start pulse at frame start.

Parameters:
LOG2N, 8, log2 of FFT points; N = 2**LOG2N; legal range 1..ADDR_W
ADDR_W, 10, width of ROM and FFT memory address
DATA_W, 32, FFT datapath width (two's complement)
SAMPLE_W, 8, stored ROM sample width (two's complement), SAMPLE_W <= DATA_W

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame when IDLE
bitrev_en  in  1  1 = write to bit-reversed address; 0 = natural order; sampled at start
scale_sh  in  5  left-shift applied to each sample, saturating; sampled at start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last sample handshake
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM read address (natural index, upper bits zero)
rom_data  in  SAMPLE_W  ROM data; valid 1 cycle after rom_en; holds its value while rom_en=0
wr_valid  out  1  write request to FFT memory
wr_ready  in  1  FFT memory accepts write
wr_addr  out  ADDR_W  FFT memory write address
wr_re  out  DATA_W  real part
wr_im  out  DATA_W  imaginary part, always 0

Behaviour:
- Reset values: busy=0, done=0, rom_en=0, rom_addr=0, wr_valid=0, wr_addr=0, wr_re=0, wr_im=0, FSM=IDLE, all counters 0. Reset is asynchronous. Asserting it mid-frame aborts the frame immediately. No done is emitted, and the next start begins a fresh frame from index 0.
- FSM states:
  - IDLE: start -> RUN. The block latches bitrev_en and scale_sh, clears rd_cnt, and sets busy=1.
  - RUN: streams the frame. -> DRAIN once all N reads are issued.
  - DRAIN: -> DONE when the pipeline is empty.
  - DONE: done=1 for one cycle, busy=0, -> IDLE.
- start outside IDLE is ignored. start in the DONE cycle is also ignored.
- Pipeline has 2 stages: ROM read (s1) and output register (s2). advance = !wr_valid | wr_ready.
- rom_en = advance & (state==RUN) & (rd_cnt < N). rom_addr = rd_cnt. rd_cnt increments on each rom_en.
- On advance: s1_valid <= rom_en and s1_idx <= rd_cnt. The output register takes s1 (wr_valid <= s1_valid).
- When advance=0, the whole pipe holds. rom_en stays 0, so ROM data is held.
- Throughput is 1 sample/cycle with wr_ready=1. First wr_valid appears 2 cycles after the start cycle.
- wr_addr = bitrev_en ? bit-reverse of the low LOG2N bits of idx : idx. Upper ADDR_W-LOG2N bits are 0.
- wr_valid/wr_addr/wr_re stay stable while wr_valid=1 and wr_ready=0.
- wr_re = sat(sext(rom_data) << scale_sh). The result saturates to 2**(DATA_W-1)-1 or -2**(DATA_W-1) on overflow. Shift 0 is a pure sign extension.
- done asserts the cycle after the Nth wr_valid&wr_ready handshake. Exactly N handshakes occur per frame, each index exactly once.
- wr_ready asserted while wr_valid=0 has no effect.

Decomposition:
- Shared package fft_sm_pkg holds: state enum (IDLE, RUN, DRAIN, DONE) and the constants ADDR_W=10 and DATA_W=32.
- Sub-module fft_sm_bitrev holds the pure combinational bit reversal, parameter LOG2N, ADDR_W in/out. It is reusable by the butterfly address generator.
- The saturating shift stays inline.

Test Plan:
1. LOG2N=8, bitrev_en=1, scale_sh=0, wr_ready=1; ROM idx1=18, idx2=-2 -> wr_addr 128 with wr_re 0x00000012, then wr_addr 64 with wr_re 0xFFFFFFFE. 256 handshakes, done 1 cycle after the last, first wr_valid 2 cycles after start.
2. bitrev_en=0 -> wr_addr sequence 0,1,2,...,255; wr_im=0 throughout.
3. Random wr_ready (about 50%) -> no sample dropped or duplicated, and outputs stable during stall. Also hold wr_ready=0 for 10 cycles at idx 100 -> rom_en=0 and rd_cnt frozen.
4. scale_sh=26, sample -58 -> wr_re 0x80000000 (saturated). Sample 1 with shift 26 -> 0x04000000.
5. Assert rst_n low at idx 37 -> all outputs 0 asynchronously and no done. New start -> frame restarts at idx 0.
6. start re-pulsed while busy, and start in the DONE cycle -> ignored. LOG2N=4 instance -> 16 samples, addresses within 0..15.

Source files
------------

// File: rtl/fft_sm_pkg.sv
// Shared state encoding and default widths for the FFT state-machine blocks.
package fft_sm_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/fft_sm_bitrev.sv
// Combinational bit reversal of the low LOG2N address bits; upper bits forced to zero.
module fft_sm_bitrev #(
  parameter int LOG2N  = 8,
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] addr_out
);
  // Upper input bits are don't-care by construction.
  logic unused_hi;
  assign unused_hi = ^addr_in;

  always_comb begin
    addr_out = '0;
    for (int i = 0; i < LOG2N; i++) begin
      addr_out[i] = addr_in[LOG2N-1-i];
    end
  end
endmodule

// File: rtl/fft_sm_input_loader.sv
// Streams one frame of N ROM samples into FFT memory: 2-stage pipe (ROM read, output reg),
// optional bit-reversed write address, saturating left shift, stalls fully on wr_ready=0.
module fft_sm_input_loader #(
  parameter int LOG2N    = 8,
  parameter int ADDR_W   = fft_sm_pkg::ADDR_W,
  parameter int DATA_W   = fft_sm_pkg::DATA_W,
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                bitrev_en,
  input  logic [4:0]          scale_sh,
  output logic                busy,
  output logic                done,
  output logic                rom_en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_data,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_re,
  output logic [DATA_W-1:0]   wr_im
);
  import fft_sm_pkg::*;

  localparam int CNT_W  = ADDR_W + 1;
  localparam int WIDE_W = DATA_W + 32;
  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(1 << LOG2N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2N) - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    rd_cnt;
  logic                bitrev_q;
  logic [4:0]          scale_q;
  logic                s1_valid;
  logic [ADDR_W-1:0]   s1_idx, s1_rev, s1_waddr;
  logic                advance;
  logic [WIDE_W-1:0]   sext, wide;
  logic [DATA_W:0]     top_bits;
  logic [DATA_W-1:0]   sat_val;

  assign advance  = !wr_valid || wr_ready;
  assign rom_en   = advance && (state == RUN) && (rd_cnt < N_CNT);
  assign rom_addr = rd_cnt[ADDR_W-1:0];
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);
  assign wr_im    = '0;

  fft_sm_bitrev #(.LOG2N(LOG2N), .ADDR_W(ADDR_W)) u_bitrev (
    .addr_in  (s1_idx),
    .addr_out (s1_rev)
  );

  assign s1_waddr = bitrev_q ? s1_rev : s1_idx;

  // Shift in a wide field; any disagreement among the bits above the result sign means overflow.
  always_comb begin
    sext     = {{(WIDE_W-SAMPLE_W){rom_data[SAMPLE_W-1]}}, rom_data};
    wide     = sext << scale_q;
    top_bits = wide[WIDE_W-1:DATA_W-1];
    if ((&top_bits) || !(|top_bits)) begin
      sat_val = wide[DATA_W-1:0];
    end else if (wide[WIDE_W-1]) begin
      sat_val = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (rom_en && (rd_cnt == LAST_CNT)) state_nxt = DRAIN;
      // Leave once s1 is empty and the output register empties at this edge.
      DRAIN:   if (!s1_valid && advance) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_cnt   <= '0;
      bitrev_q <= 1'b0;
      scale_q  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start) begin
        bitrev_q <= bitrev_en;
        scale_q  <= scale_sh;
        rd_cnt   <= '0;
      end else if (rom_en) begin
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_re    <= '0;
    end else if (advance) begin
      s1_valid <= rom_en;
      s1_idx   <= rd_cnt[ADDR_W-1:0];
      wr_valid <= s1_valid;
      if (s1_valid) begin
        wr_addr <= s1_waddr;
        wr_re   <= sat_val;
      end
    end
  end
endmodule

// File: tb/tb_fft_sm_input_loader.sv
// Randomized bench for fft_sm_input_loader (LOG2N=8 and LOG2N=4 instances) against an arithmetic model.
module tb_fft_sm_input_loader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start8 = 1'b0, start4 = 1'b0, bitrev_en = 1'b0, wr_ready = 1'b0;
  logic [4:0] scale_sh = '0;

  logic busy8, done8, rom_en8, wr_valid8;
  logic [AW-1:0] rom_addr8, wr_addr8;
  logic [SW-1:0] rom_data8 = '0;
  logic [DW-1:0] wr_re8, wr_im8;

  logic busy4, done4, rom_en4, wr_valid4;
  logic [AW-1:0] rom_addr4, wr_addr4;
  logic [SW-1:0] rom_data4 = '0;
  logic [DW-1:0] wr_re4, wr_im4;

  logic [SW-1:0] rom_mem [0:1023];
  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] g_addr[$];
  logic [DW-1:0] g_re[$];
  logic [DW-1:0] g_im[$];
  int first_lat, last_hs, done_cyc, stall_err, busy_err, freeze_err, post_err, bad_idx;

  always #5 clk = ~clk;

  fft_sm_input_loader #(.LOG2N(8), .ADDR_W(AW), .DATA_W(DW), .SAMPLE_W(SW)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bitrev_en(bitrev_en), .scale_sh(scale_sh),
    .busy(busy8), .done(done8), .rom_en(rom_en8), .rom_addr(rom_addr8), .rom_data(rom_data8),
    .wr_valid(wr_valid8), .wr_ready(wr_ready), .wr_addr(wr_addr8), .wr_re(wr_re8), .wr_im(wr_im8)
  );

  fft_sm_input_loader #(.LOG2N(4), .ADDR_W(AW), .DATA_W(DW), .SAMPLE_W(SW)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bitrev_en(bitrev_en), .scale_sh(scale_sh),
    .busy(busy4), .done(done4), .rom_en(rom_en4), .rom_addr(rom_addr4), .rom_data(rom_data4),
    .wr_valid(wr_valid4), .wr_ready(wr_ready), .wr_addr(wr_addr4), .wr_re(wr_re4), .wr_im(wr_im4)
  );

  // Synchronous ROM: data one cycle after enable, held otherwise.
  always @(posedge clk) if (rom_en8) rom_data8 <= rom_mem[rom_addr8];
  always @(posedge clk) if (rom_en4) rom_data4 <= rom_mem[rom_addr4];

  function automatic int rev_model(input int i, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++) r = (r << 1) | ((i >> b) & 1);
    return r;
  endfunction

  function automatic logic [31:0] re_model(input logic [7:0] s, input int sh);
    longint v;
    v = longint'($signed(s)) * (longint'(1) << sh);
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    if (v < -64'sd2147483648) v = -64'sd2147483648;
    return v[31:0];
  endfunction

  function automatic int frame_errors(input bit br, input int sh);
    int e = 0;
    int exp_a;
    bad_idx = -1;
    if (g_addr.size() != 256) e++;
    for (int k = 0; k < g_addr.size(); k++) begin
      exp_a = br ? rev_model(k, 8) : k;
      if (g_addr[k] !== AW'(exp_a) || g_re[k] !== re_model(rom_mem[k], sh) || g_im[k] !== '0) begin
        e++;
        if (bad_idx < 0) bad_idx = k;
      end
    end
    return e;
  endfunction

  task automatic fill_rom;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 8'($urandom);
  endtask

  // Runs one frame on dut8. mode: 0 ready=1, 1 random ready, 2 random ready plus a 10-cycle hold at idx 100.
  task automatic run8(input bit br, input logic [4:0] sh, input int mode, input bit mid_start, input bit done_start);
    int cyc, hold;
    bit prev_stall, hold_used, have_frz;
    logic [AW-1:0] p_addr, frz_addr;
    logic [DW-1:0] p_re;
    g_addr.delete(); g_re.delete(); g_im.delete();
    first_lat = -1; last_hs = -1; done_cyc = -1;
    stall_err = 0; busy_err = 0; freeze_err = 0; post_err = 0;
    prev_stall = 0; hold = 0; hold_used = 0; have_frz = 0; p_addr = '0; p_re = '0; frz_addr = '0;
    bitrev_en = br; scale_sh = sh; wr_ready = 1'b1;
    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    bitrev_en = ~br; scale_sh = ~sh;
    cyc = 0;
    while (cyc < 4000) begin
      if (mode == 2 && !hold_used && g_addr.size() == 100) begin hold = 10; hold_used = 1; end
      if (hold > 0) wr_ready = 1'b0;
      else if (mode >= 1) wr_ready = 1'($urandom_range(0, 1));
      else wr_ready = 1'b1;
      start8 = (mid_start && (cyc == 50 || cyc == 51));
      @(negedge clk);
      if (hold > 0) begin
        if (wr_valid8) begin
          if (rom_en8) freeze_err++;
          if (have_frz && rom_addr8 !== frz_addr) freeze_err++;
          frz_addr = rom_addr8; have_frz = 1;
        end
        hold--;
      end
      if (done8 ? busy8 : !busy8) busy_err++;
      if (wr_valid8 && first_lat < 0) first_lat = cyc;
      if (prev_stall && (!wr_valid8 || wr_addr8 !== p_addr || wr_re8 !== p_re)) stall_err++;
      prev_stall = wr_valid8 && !wr_ready;
      p_addr = wr_addr8; p_re = wr_re8;
      if (wr_valid8 && wr_ready) begin
        g_addr.push_back(wr_addr8); g_re.push_back(wr_re8); g_im.push_back(wr_im8);
        last_hs = cyc;
      end
      if (done8) begin done_cyc = cyc; break; end
      @(posedge clk); #1;
      cyc++;
    end
    start8 = done_start;
    @(posedge clk); #1 start8 = 1'b0; wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done8 || busy8 || rom_en8 || wr_valid8) post_err++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    logic [87:0] outs;
    repeat (3) @(posedge clk);
    #2;
    outs = {busy8, done8, rom_en8, rom_addr8, wr_valid8, wr_addr8, wr_re8, wr_im8};
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL reset_state: got %h want 0", outs); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy8, done8, rom_en8, wr_valid8} !== 4'b0) begin
      n_bad++; $display("FAIL idle_after_reset: got %b want 0000", {busy8, done8, rom_en8, wr_valid8});
    end
  endtask

  task automatic test_bitrev_frame;
    int e;
    fill_rom();
    rom_mem[1] = 8'd18; rom_mem[2] = 8'hFE;
    run8(1'b1, 5'd0, 0, 1'b0, 1'b0);
    n_cmp++;
    if (g_addr.size() !== 256) begin n_bad++; $display("FAIL bitrev_count: got %0d want 256", g_addr.size()); end
    n_cmp++;
    if ({g_addr[1], g_re[1]} !== {10'd128, 32'h00000012}) begin
      n_bad++; $display("FAIL bitrev_idx1: got addr %0d re %h want 128 00000012", g_addr[1], g_re[1]);
    end
    n_cmp++;
    if ({g_addr[2], g_re[2]} !== {10'd64, 32'hFFFFFFFE}) begin
      n_bad++; $display("FAIL bitrev_idx2: got addr %0d re %h want 64 fffffffe", g_addr[2], g_re[2]);
    end
    n_cmp++;
    if (first_lat !== 2) begin n_bad++; $display("FAIL first_valid_latency: got %0d want 2", first_lat); end
    n_cmp++;
    if (done_cyc < 0 || done_cyc !== last_hs + 1) begin
      n_bad++; $display("FAIL done_timing: done at %0d, last handshake at %0d", done_cyc, last_hs);
    end
    e = frame_errors(1'b1, 0);
    n_cmp++;
    if (e !== 0) begin n_bad++; $display("FAIL bitrev_frame: got %0d bad entries (first %0d) want 0", e, bad_idx); end
    n_cmp++;
    if (busy_err + post_err !== 0) begin n_bad++; $display("FAIL busy_done_shape: got %0d/%0d want 0/0", busy_err, post_err); end
  endtask

  task automatic test_natural_order;
    int e;
    fill_rom();
    run8(1'b0, 5'd1, 0, 1'b0, 1'b0);
    e = frame_errors(1'b0, 1);
    n_cmp++;
    if (e !== 0) begin n_bad++; $display("FAIL natural_frame: got %0d bad entries (first %0d) want 0", e, bad_idx); end
    n_cmp++;
    if (g_addr[255] !== 10'd255) begin n_bad++; $display("FAIL natural_last_addr: got %0d want 255", g_addr[255]); end
  endtask

  task automatic test_stall;
    int e;
    fill_rom();
    run8(1'b1, 5'd2, 2, 1'b0, 1'b0);
    e = frame_errors(1'b1, 2);
    n_cmp++;
    if (e !== 0) begin n_bad++; $display("FAIL stall_frame: got %0d bad entries (first %0d) want 0", e, bad_idx); end
    n_cmp++;
    if (stall_err !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_err); end
    n_cmp++;
    if (freeze_err !== 0) begin n_bad++; $display("FAIL hold_freeze: got %0d rom moves want 0", freeze_err); end
    n_cmp++;
    if (done_cyc < 0 || done_cyc !== last_hs + 1) begin
      n_bad++; $display("FAIL stall_done_timing: done at %0d, last handshake at %0d", done_cyc, last_hs);
    end
  endtask

  task automatic test_saturate;
    int e;
    fill_rom();
    rom_mem[0] = 8'hC6; rom_mem[1] = 8'd1; rom_mem[2] = 8'd100;
    run8(1'b0, 5'd26, 1, 1'b0, 1'b0);
    n_cmp++;
    if (g_re[0] !== 32'h80000000) begin n_bad++; $display("FAIL sat_neg: got %h want 80000000", g_re[0]); end
    n_cmp++;
    if (g_re[1] !== 32'h04000000) begin n_bad++; $display("FAIL shift_one: got %h want 04000000", g_re[1]); end
    n_cmp++;
    if (g_re[2] !== 32'h7FFFFFFF) begin n_bad++; $display("FAIL sat_pos: got %h want 7fffffff", g_re[2]); end
    e = frame_errors(1'b0, 26);
    n_cmp++;
    if (e !== 0) begin n_bad++; $display("FAIL sat_frame: got %0d bad entries (first %0d) want 0", e, bad_idx); end
  endtask

  task automatic test_reset_abort;
    int n, cnt, abort_err, e;
    logic [10:0] pre;
    logic [87:0] outs;
    fill_rom();
    bitrev_en = 1'b0; scale_sh = 5'd0; wr_ready = 1'b1;
    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    n = 0; cnt = 0;
    while (n < 37 && cnt < 2000) begin
      @(negedge clk);
      if (wr_valid8 && wr_ready) n++;
      @(posedge clk); #1;
      cnt++;
    end
    pre = {wr_valid8, wr_addr8};
    n_cmp++;
    if (pre !== {1'b1, 10'd37}) begin n_bad++; $display("FAIL abort_point: got %h want %h", pre, {1'b1, 10'd37}); end
    #2 rst_n = 1'b0;
    #1;
    outs = {busy8, done8, rom_en8, rom_addr8, wr_valid8, wr_addr8, wr_re8, wr_im8};
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL async_reset_outputs: got %h want 0", outs); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    abort_err = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done8 || busy8) abort_err++;
    end
    n_cmp++;
    if (abort_err !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d cycles with done/busy want 0", abort_err); end
    fill_rom();
    run8(1'b0, 5'd4, 0, 1'b0, 1'b0);
    n_cmp++;
    if (g_addr[0] !== 10'd0) begin n_bad++; $display("FAIL restart_idx0: got %0d want 0", g_addr[0]); end
    e = frame_errors(1'b0, 4);
    n_cmp++;
    if (e !== 0) begin n_bad++; $display("FAIL restart_frame: got %0d bad entries (first %0d) want 0", e, bad_idx); end
  endtask

  task automatic test_ignored_start;
    int e;
    fill_rom();
    run8(1'b1, 5'd7, 1, 1'b1, 1'b1);
    e = frame_errors(1'b1, 7);
    n_cmp++;
    if (e !== 0) begin n_bad++; $display("FAIL restart_ignored_frame: got %0d bad entries (first %0d) want 0", e, bad_idx); end
    n_cmp++;
    if (post_err !== 0) begin n_bad++; $display("FAIL start_in_done: got %0d active cycles want 0", post_err); end
    n_cmp++;
    if (busy_err !== 0) begin n_bad++; $display("FAIL busy_during_frame: got %0d bad cycles want 0", busy_err); end
  endtask

  task automatic test_small_n;
    logic [AW-1:0] a4[$];
    logic [DW-1:0] r4[$];
    int d, last, errs;
    fill_rom();
    bitrev_en = 1'b1; scale_sh = 5'd3; wr_ready = 1'b1;
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    bitrev_en = 1'b0; scale_sh = 5'd0;
    d = -1; last = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (wr_valid4 && wr_ready) begin a4.push_back(wr_addr4); r4.push_back(wr_re4); last = c; end
      if (done4) begin d = c; break; end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (a4.size() !== 16) begin n_bad++; $display("FAIL small_count: got %0d want 16", a4.size()); end
    errs = 0;
    for (int k = 0; k < a4.size(); k++) begin
      if (k > 15 || a4[k] > 10'd15 || a4[k] !== AW'(rev_model(k, 4)) || r4[k] !== re_model(rom_mem[k], 3)) errs++;
    end
    n_cmp++;
    if (errs !== 0) begin n_bad++; $display("FAIL small_frame: got %0d bad entries want 0", errs); end
    n_cmp++;
    if (d < 0 || d !== last + 1) begin n_bad++; $display("FAIL small_done: done at %0d, last handshake at %0d", d, last); end
  endtask

  initial begin
    test_reset();
    test_bitrev_frame();
    test_natural_order();
    test_stall();
    test_saturate();
    test_reset_abort();
    test_ignored_start();
    test_small_n();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
